mdom_wvb_conf_bundle_builder: RTL

Register-side builder for the 40-bit mDOM waveform-buffer configuration bundle consumed by the per-channel wvb fan-out. It accepts 16-bit local-bus writes into shadow registers and commits them to the bundle atomically, never while the waveform buffer is busy. It also runs the arm handshake: it sets the bundle arm bit, then clears it on trigger completion, software disarm, or timeout.

---
 rtl/mdom_wvb_conf_bundle_builder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mdom_wvb_conf_bundle_builder.sv
// Waveform-buffer configuration bundle builder.
// Local-bus writes land in shadow registers. A commit copies them into the 40-bit bundle
// atomically, and is held off while the waveform buffer is busy. The arm handshake drives
// bundle[37] and clears it on trig_done, disarm or timeout.
module mdom_wvb_conf_bundle_builder #(
   parameter int unsigned ARM_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [2:0]  addr,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   input  logic        wvb_busy,
   input  logic        trig_done,
   output logic [39:0] bundle
);

   typedef enum logic [1:0] {StIdle, StPend, StArmed} state_e;

   state_e      state_q, state_d;
   logic [11:0] cnst_q, cnst_d, test_q, test_d;
   logic [4:0]  pre_q, pre_d;
   logic [7:0]  post_q, post_d;
   logic        trig_mode_q, trig_mode_d, cnst_run_q, cnst_run_d;
   logic        commit_pend_q, commit_pend_d, arm_pend_q, arm_pend_d;
   logic        tflag_q, tflag_d;
   logic [15:0] cnt_q, cnt_d;
   logic [39:0] bundle_q, bundle_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;

   logic cmd_wr, commit_req, arm_req, disarm_req, commit_now, timeout_hit, arm_eff;

   assign cmd_wr     = wr_en && (addr == 3'd4);
   assign commit_req = cmd_wr && wr_data[0];
   // Disarm wins over arm when both arrive in the same write.
   assign arm_req    = cmd_wr && wr_data[1] && !wr_data[2];
   assign disarm_req = cmd_wr && wr_data[2];
   assign commit_now = (commit_req || commit_pend_q) && !wvb_busy;
   // Counter holds (cycles armed - 1); clearing when it reaches ARM_TIMEOUT-1 keeps arm
   // high for exactly ARM_TIMEOUT cycles.
   assign timeout_hit = (ARM_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == ARM_TIMEOUT);
   assign arm_eff     = (arm_pend_q || arm_req) && !disarm_req;

   // Shadow register writes.
   always_comb begin
      cnst_d      = cnst_q;
      test_d      = test_q;
      pre_d       = pre_q;
      post_d      = post_q;
      trig_mode_d = trig_mode_q;
      cnst_run_d  = cnst_run_q;
      if (wr_en) begin
         case (addr)
            3'd0: cnst_d = wr_data[11:0];
            3'd1: test_d = wr_data[11:0];
            3'd2: begin
               pre_d  = wr_data[12:8];
               post_d = wr_data[7:0];
            end
            3'd3: begin
               trig_mode_d = wr_data[0];
               cnst_run_d  = wr_data[1];
            end
            default: ;
         endcase
      end
   end

   // Commit / arm state machine and bundle next state.
   always_comb begin
      state_d       = state_q;
      bundle_d      = bundle_q;
      commit_pend_d = commit_pend_q;
      arm_pend_d    = arm_pend_q;
      tflag_d       = tflag_q;
      cnt_d         = '0;
      if (commit_now) begin
         bundle_d[39:38] = {cnst_run_q, trig_mode_q};
         bundle_d[36:0]  = {pre_q, post_q, test_q, cnst_q};
         commit_pend_d   = 1'b0;
      end else if (commit_req) begin
         commit_pend_d = 1'b1;
      end
      unique case (state_q)
         StIdle: begin
            if (commit_req && wvb_busy) begin
               state_d    = StPend;
               arm_pend_d = arm_req;
            end else if (arm_req) begin
               bundle_d[37] = 1'b1;
               tflag_d      = 1'b0;
               state_d      = StArmed;
            end
         end
         StPend: begin
            arm_pend_d = arm_eff;
            if (commit_now) begin
               arm_pend_d = 1'b0;
               if (arm_eff) begin
                  bundle_d[37] = 1'b1;
                  tflag_d      = 1'b0;
                  state_d      = StArmed;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StArmed: begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (trig_done || disarm_req || timeout_hit) begin
               bundle_d[37] = 1'b0;
               tflag_d      = timeout_hit && !trig_done && !disarm_req;
               state_d      = commit_pend_d ? StPend : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered read port; data holds between reads.
   always_comb begin
      rd_valid_d = rd_en;
      rd_data_d  = rd_data_q;
      if (rd_en) begin
         case (addr)
            3'd0:    rd_data_d = {4'b0, cnst_q};
            3'd1:    rd_data_d = {4'b0, test_q};
            3'd2:    rd_data_d = {3'b0, pre_q, post_q};
            3'd3:    rd_data_d = {14'b0, cnst_run_q, trig_mode_q};
            3'd5:    rd_data_d = {13'b0, tflag_q, state_q == StArmed, commit_pend_q};
            default: rd_data_d = '0;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         cnst_q        <= '0;
         test_q        <= '0;
         pre_q         <= '0;
         post_q        <= '0;
         trig_mode_q   <= 1'b0;
         cnst_run_q    <= 1'b0;
         commit_pend_q <= 1'b0;
         arm_pend_q    <= 1'b0;
         tflag_q       <= 1'b0;
         cnt_q         <= '0;
         bundle_q      <= '0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnst_q        <= cnst_d;
         test_q        <= test_d;
         pre_q         <= pre_d;
         post_q        <= post_d;
         trig_mode_q   <= trig_mode_d;
         cnst_run_q    <= cnst_run_d;
         commit_pend_q <= commit_pend_d;
         arm_pend_q    <= arm_pend_d;
         tflag_q       <= tflag_d;
         cnt_q         <= cnt_d;
         bundle_q      <= bundle_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
      end
   end

   assign bundle   = bundle_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule
